// File: rtl/debounce_pkg.sv
// debounce_pkg
// Shared types and constants for the debounce_toggle_gen input conditioner.
//   state_t        : debounce FSM state encoding
//   GLITCH_CNT_W   : width of the optional aborted-glitch counter
//   GLITCH_CNT_MAX : saturation value of that counter
package debounce_pkg;

  typedef enum logic [1:0] {
    S_LO    = 2'd0,
    PEND_HI = 2'd1,
    S_HI    = 2'd2,
    PEND_LO = 2'd3
  } state_t;

  localparam int GLITCH_CNT_W = 8;
  localparam logic [GLITCH_CNT_W-1:0] GLITCH_CNT_MAX = 8'hFF;

endpackage

// File: rtl/sync_chain.sv
// sync_chain
// Multi-flop synchroniser bringing an asynchronous pad signal into the clk
// domain. Shifts every clock; there is no enable.
// Parameters:
//   SYNC_STAGES : number of flops in the chain (2..4)
// Ports:
//   clk : design clock, rising edge
//   rst : asynchronous active-high reset, clears every stage
//   d   : asynchronous input
//   q   : synchronised output (last stage)
module sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stage;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage <= '0;
    end else begin
      stage <= {stage[SYNC_STAGES-2:0], d};
    end
  end

  assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_toggle_gen.sv
// debounce_toggle_gen
// Input conditioner for a raw pad signal: synchronises din_raw, debounces it
// with a four-state FSM and produces a clean level plus single-cycle rise and
// fall pulses. rise_pulse serves as the toggle enable of a downstream T flop.
// Parameters:
//   SYNC_STAGES : synchroniser depth (2..4)
//   DB_CYCLES   : stable synchronised cycles needed to accept a new level
// Ports:
//   clk         : design clock, rising edge
//   rst         : asynchronous active-high reset
//   ena         : advance enable; 0 freezes FSM and counter, blocks pulses
//   din_raw     : raw asynchronous pad input
//   clean_level : debounced level (registered)
//   rise_pulse  : one-cycle pulse on an accepted 0->1
//   fall_pulse  : one-cycle pulse on an accepted 1->0
//   busy        : high while a new level is pending
// Optional build macro DEBOUNCE_GLITCH_CNT_EN adds:
//   glitch_clr  : synchronous clear of glitch_cnt (wins over increment)
//   glitch_cnt  : saturating count of aborted pending transitions
module debounce_toggle_gen
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  logic                    din_raw,
`ifdef DEBOUNCE_GLITCH_CNT_EN
  input  logic                    glitch_clr,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt,
`endif
  output logic                    clean_level,
  output logic                    rise_pulse,
  output logic                    fall_pulse,
  output logic                    busy
);

  localparam int CNT_W = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Stage 0: synchronise the pad input
  logic s_p0;

  sync_chain #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (din_raw),
    .q  (s_p0)
  );

  // Stage 1: debounce FSM and counter
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             commit_rise, commit_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_LO;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // With ena low everything holds and no commit can be raised, so a
  // pending commit simply waits for the next enabled edge.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    commit_rise = 1'b0;
    commit_fall = 1'b0;
    if (ena) begin
      unique case (state)
        S_LO: begin
          if (s_p0) begin
            state_nxt = PEND_HI;
            cnt_nxt   = '0;
          end
        end
        PEND_HI: begin
          if (!s_p0) begin
            state_nxt = S_LO;
          end else if (cnt == CNT_LAST) begin
            state_nxt   = S_HI;
            commit_rise = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        S_HI: begin
          if (!s_p0) begin
            state_nxt = PEND_LO;
            cnt_nxt   = '0;
          end
        end
        PEND_LO: begin
          if (s_p0) begin
            state_nxt = S_HI;
          end else if (cnt == CNT_LAST) begin
            state_nxt   = S_LO;
            commit_fall = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
      endcase
    end
  end

  assign busy = (state == PEND_HI) || (state == PEND_LO);

  // Stage 2: registered level and pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clean_level <= 1'b0;
      rise_pulse  <= 1'b0;
      fall_pulse  <= 1'b0;
    end else begin
      rise_pulse <= commit_rise;
      fall_pulse <= commit_fall;
      if (commit_rise) begin
        clean_level <= 1'b1;
      end else if (commit_fall) begin
        clean_level <= 1'b0;
      end
    end
  end

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic abort;

  // A pending transition that sees the old level again is a rejected glitch.
  assign abort = ena && (((state == PEND_HI) && !s_p0) ||
                         ((state == PEND_LO) && s_p0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      glitch_cnt <= '0;
    end else if (glitch_clr) begin
      glitch_cnt <= '0;
    end else if (abort && (glitch_cnt != GLITCH_CNT_MAX)) begin
      glitch_cnt <= glitch_cnt + GLITCH_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_debounce_toggle_gen.sv
// tb_debounce_toggle_gen
// Directed bench for debounce_toggle_gen with default parameters. A
// run-length model (consecutive enabled edges on which the synchronised input
// disagrees with the accepted level) predicts every output each cycle;
// hand-computed edge numbers pin the model in each scenario.
module tb_debounce_toggle_gen;

  localparam int SYNC_STAGES = 2;
  localparam int DB_CYCLES   = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ena = 1'b1;
  logic din_raw = 1'b0;
  logic clean_level, rise_pulse, fall_pulse, busy;
`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic       glitch_clr = 1'b0;
  logic [7:0] glitch_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  debounce_toggle_gen #(
    .SYNC_STAGES(SYNC_STAGES),
    .DB_CYCLES  (DB_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .din_raw    (din_raw),
`ifdef DEBOUNCE_GLITCH_CNT_EN
    .glitch_clr (glitch_clr),
    .glitch_cnt (glitch_cnt),
`endif
    .clean_level(clean_level),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .busy       (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit din_hist[$];
  bit m_level = 1'b0;
  bit m_rise  = 1'b0;
  bit m_fall  = 1'b0;
  int m_run   = 0;
  int m_glitch = 0;

  always @(posedge clk or posedge rst) begin
    bit s;
    bit aborted;
    if (rst) begin
      din_hist.delete();
      for (int i = 0; i < SYNC_STAGES; i++) din_hist.push_back(1'b0);
      m_level = 0; m_rise = 0; m_fall = 0; m_run = 0; m_glitch = 0;
    end else begin
      // The FSM sees din_raw as it was SYNC_STAGES edges ago.
      s = din_hist.pop_front();
      din_hist.push_back(din_raw);
      m_rise  = 0;
      m_fall  = 0;
      aborted = 0;
      if (ena) begin
        if (s != m_level) begin
          m_run++;
          if (m_run == DB_CYCLES + 1) begin
            m_level = s;
            m_rise  = s;
            m_fall  = !s;
            m_run   = 0;
          end
        end else if (m_run > 0) begin
          m_run   = 0;
          aborted = 1;
        end
      end
`ifdef DEBOUNCE_GLITCH_CNT_EN
      if (glitch_clr) m_glitch = 0;
      else if (aborted && m_glitch < 255) m_glitch++;
`endif
    end
  end

  always @(negedge clk) begin
    chk("model_clean_level", clean_level, m_level);
    chk("model_rise_pulse", rise_pulse, m_rise);
    chk("model_fall_pulse", fall_pulse, m_fall);
    chk("model_busy", busy, m_run > 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    chk("model_glitch_cnt", glitch_cnt, m_glitch);
`endif
  end

  // ---------------- directed stimulus ----------------
  initial begin
    bit saw_pulse;

    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset_clean", clean_level, 0);
    chk("reset_rise", rise_pulse, 0);
    chk("reset_fall", fall_pulse, 0);
    chk("reset_busy", busy, 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    chk("reset_glitch", glitch_cnt, 0);
`endif

    // Clean rise, released from reset with din_raw already high
    @(negedge clk);
    rst = 1'b0;
    din_raw = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      @(negedge clk);
      chk("rise_pulse_at19", rise_pulse, e == 19);
      chk("rise_clean", clean_level, e >= 19);
      chk("rise_busy", busy, e >= 3 && e <= 18);
    end

    // Clean fall
    din_raw = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      @(negedge clk);
      chk("fall_pulse_at19", fall_pulse, e == 19);
      chk("fall_clean", clean_level, e < 19);
      chk("fall_busy", busy, e >= 3 && e <= 18);
    end

    // Glitch reject: 10 cycles high is far short of the debounce window
    saw_pulse = 0;
    din_raw = 1'b1;
    repeat (10) begin
      @(negedge clk);
      saw_pulse |= rise_pulse | fall_pulse;
    end
    din_raw = 1'b0;
    repeat (30) begin
      @(negedge clk);
      saw_pulse |= rise_pulse | fall_pulse;
    end
    chk("glitch_no_pulse", saw_pulse, 0);
    chk("glitch_clean", clean_level, 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    chk("glitch_cnt_one", glitch_cnt, 1);
    glitch_clr = 1'b1;
    @(negedge clk);
    glitch_clr = 1'b0;
    chk("glitch_clr_zero", glitch_cnt, 0);
`endif

    // Bounce train: five 3-high/3-low bursts, then held high
    repeat (5) begin
      din_raw = 1'b1;
      repeat (3) @(negedge clk);
      din_raw = 1'b0;
      repeat (3) @(negedge clk);
    end
    din_raw = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      @(negedge clk);
      chk("bounce_rise_at19", rise_pulse, e == 19);
    end
`ifdef DEBOUNCE_GLITCH_CNT_EN
    chk("bounce_glitch_cnt", glitch_cnt, 5);
`endif

    // Return low, then freeze ena for 8 cycles in the middle of PEND_HI
    din_raw = 1'b0;
    repeat (40) @(negedge clk);
    chk("pre_freeze_clean", clean_level, 0);
    din_raw = 1'b1;
    for (int e = 1; e <= 45; e++) begin
      @(negedge clk);
      chk("freeze_rise_at27", rise_pulse, e == 27);
      chk("freeze_clean", clean_level, e >= 27);
      chk("freeze_busy", busy, e >= 3 && e <= 26);
      if (e == 10) ena = 1'b0;
      if (e == 18) ena = 1'b1;
    end

    // Asynchronous reset while in PEND_HI with cnt=9
    din_raw = 1'b0;
    repeat (40) @(negedge clk);
    din_raw = 1'b1;
    repeat (12) @(negedge clk);
    chk("pend_busy_before_rst", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_clean", clean_level, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= 25; e++) begin
      @(negedge clk);
      chk("post_rst_rise_at19", rise_pulse, e == 19);
    end

    // Asynchronous reset while in S_HI
    chk("shi_clean_before_rst", clean_level, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_shi_clean", clean_level, 0);
    chk("async_rst_shi_rise", rise_pulse, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= 25; e++) begin
      @(negedge clk);
      chk("post_rst2_rise_at19", rise_pulse, e == 19);
    end

`ifdef DEBOUNCE_GLITCH_CNT_EN
    // Saturation: 300 aborted low-going glitches from the high level
    repeat (300) begin
      din_raw = 1'b0;
      repeat (2) @(negedge clk);
      din_raw = 1'b1;
      repeat (3) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    chk("glitch_saturated", glitch_cnt, 255);
    chk("sat_clean_held", clean_level, 1);
    glitch_clr = 1'b1;
    @(negedge clk);
    glitch_clr = 1'b0;
    chk("glitch_clr_after_sat", glitch_cnt, 0);
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
